// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] types and constants for the iterative permutation core.
package keccak_pkg;

    localparam int KECCAK_LANES      = 25;
    localparam int KECCAK_LAST_ROUND = 23;
    localparam int ROUND_W           = 6;

    typedef logic [63:0] lane_t;
    typedef lane_t [KECCAK_LANES-1:0] state_t;

endpackage

// File: rtl/state_reg1600.sv
// Load-enabled 1600-bit state register with asynchronous active-low clear.
module state_reg1600 #(
    parameter int W = 1600
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else if (load_i) begin
            state_q <= d_i;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/round_demux1600.sv
// Routes a permutation-round result to the feedback loop or the final-output holding register.
// Optional delivered-hash counter enabled by defining ROUND_DEMUX_HASH_COUNT_EN.
module round_demux1600
    import keccak_pkg::*;
#(
    parameter int LAST_ROUND = KECCAK_LAST_ROUND,
    parameter int LANES      = KECCAK_LANES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample,
    input  logic [ROUND_W-1:0] iround,
    input  state_t             i,
    output logic               loop_good,
    output state_t             loop_o,
    output logic [4:0]         loop_round,
    output logic               o_valid,
    input  logic               o_ready,
    output state_t             o,
    output logic               ofull,
    output logic               overrun,
    output logic               bad_round,
    output logic [31:0]        hash_count
);

    localparam int                 STATE_W = LANES * 64;
    localparam logic [ROUND_W-1:0] LAST_R  = ROUND_W'(LAST_ROUND);

    logic       loop_load;
    logic       final_in;
    logic       illegal_in;
    logic       drain;
    logic       out_load;
    logic       loop_good_q, loop_good_d;
    logic [4:0] loop_round_q, loop_round_d;
    logic       o_valid_q, o_valid_d;
    logic       overrun_q, overrun_d;
    logic       bad_round_q, bad_round_d;

    assign loop_load  = sample && (iround < LAST_R);
    assign final_in   = sample && (iround == LAST_R);
    assign illegal_in = sample && (iround > LAST_R);
    assign drain      = o_valid_q && o_ready;
    // A final result may load when the holder is empty or is being drained this cycle.
    assign out_load   = final_in && (!o_valid_q || o_ready);

    always_comb begin
        loop_good_d  = loop_load;
        loop_round_d = loop_round_q;
        if (loop_load) begin
            loop_round_d = iround[4:0] + 5'd1;
        end
        o_valid_d   = out_load || (o_valid_q && !o_ready);
        overrun_d   = overrun_q || (final_in && o_valid_q && !o_ready);
        bad_round_d = bad_round_q || illegal_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_good_q  <= 1'b0;
            loop_round_q <= '0;
            o_valid_q    <= 1'b0;
            overrun_q    <= 1'b0;
            bad_round_q  <= 1'b0;
        end else begin
            loop_good_q  <= loop_good_d;
            loop_round_q <= loop_round_d;
            o_valid_q    <= o_valid_d;
            overrun_q    <= overrun_d;
            bad_round_q  <= bad_round_d;
        end
    end

    state_reg1600 #(.W(STATE_W)) u_loop_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (loop_load),
        .d_i    (i),
        .q_o    (loop_o)
    );

    state_reg1600 #(.W(STATE_W)) u_out_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (out_load),
        .d_i    (i),
        .q_o    (o)
    );

`ifdef ROUND_DEMUX_HASH_COUNT_EN
    logic [31:0] hash_count_q, hash_count_d;

    assign hash_count_d = drain ? hash_count_q + 32'd1 : hash_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_count_q <= '0;
        end else begin
            hash_count_q <= hash_count_d;
        end
    end

    assign hash_count = hash_count_q;
`else
    assign hash_count = '0;
`endif

    assign loop_good  = loop_good_q;
    assign loop_round = loop_round_q;
    assign o_valid    = o_valid_q;
    assign ofull      = o_valid_q && !o_ready;
    assign overrun    = overrun_q;
    assign bad_round  = bad_round_q;

endmodule

// File: tb/tb_round_demux1600.sv
// Scoreboard bench for round_demux1600: loop and output transfers are checked by a monitor.
module tb_round_demux1600;
    import keccak_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sample;
    logic [5:0]  iround;
    state_t      i;
    logic        loop_good;
    state_t      loop_o;
    logic [4:0]  loop_round;
    logic        o_valid;
    logic        o_ready;
    state_t      o;
    logic        ofull;
    logic        overrun;
    logic        bad_round;
    logic [31:0] hash_count;

    int tests;
    int fails;

    typedef struct {
        logic [4:0] rnd;
        state_t     st;
    } loop_exp_t;

    loop_exp_t loop_q[$];
    state_t    out_q[$];

`ifdef ROUND_DEMUX_HASH_COUNT_EN
    localparam bit HC_EN = 1'b1;
`else
    localparam bit HC_EN = 1'b0;
`endif

    round_demux1600 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .iround     (iround),
        .i          (i),
        .loop_good  (loop_good),
        .loop_o     (loop_o),
        .loop_round (loop_round),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o          (o),
        .ofull      (ofull),
        .overrun    (overrun),
        .bad_round  (bad_round),
        .hash_count (hash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input state_t act, input state_t exp);
        int bad_lane;
        bad_lane = -1;
        for (int k = 0; k < 25; k++) begin
            if (bad_lane < 0 && act[k] !== exp[k]) bad_lane = k;
        end
        tests++;
        if (bad_lane >= 0) begin
            fails++;
            $display("FAIL %s: lane %0d got 0x%0h expected 0x%0h",
                     name, bad_lane, act[bad_lane], exp[bad_lane]);
        end
    endtask

    // Monitor: compares every loop pulse and every output handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (loop_good) begin
                if (loop_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL loop_unexpected: got loop_good=1 expected 0");
                end else begin
                    loop_exp_t e;
                    e = loop_q.pop_front();
                    chk("loop_round", 64'(loop_round), 64'(e.rnd));
                    chk_state("loop_o", loop_o, e.st);
                end
            end
            if (o_valid && o_ready) begin
                if (out_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got o_valid=1 expected 0");
                end else begin
                    state_t e;
                    e = out_q.pop_front();
                    chk_state("o_handshake", o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic state_t lane0(input logic [63:0] v);
        state_t s;
        s = '0;
        s[0] = v;
        return s;
    endfunction

    task automatic issue(input logic [5:0] r, input state_t s);
        sample = 1'b1;
        iround = r;
        i      = s;
        step();
        sample = 1'b0;
        iround = '0;
        i      = '0;
    endtask

    initial begin
        state_t    ramp;
        loop_exp_t le;

        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        sample  = 1'b0;
        iround  = '0;
        i       = '0;
        o_ready = 1'b0;
        #12;
        chk("rst_loop_good", 64'(loop_good), 64'd0);
        chk("rst_loop_round", 64'(loop_round), 64'd0);
        chk_state("rst_loop_o", loop_o, '0);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk_state("rst_o", o, '0);
        chk("rst_flags", {62'd0, overrun, bad_round}, 64'd0);
        chk("rst_hash", 64'(hash_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Loop routing: round 5 with lane k = k.
        for (int k = 0; k < 25; k++) ramp[k] = 64'(k);
        le.rnd = 5'd6;
        le.st  = ramp;
        loop_q.push_back(le);
        issue(6'd5, ramp);
        chk("loop_good_pulse", 64'(loop_good), 64'd1);
        chk("loop_o_valid_idle", 64'(o_valid), 64'd0);
        step();
        chk("loop_good_drop", 64'(loop_good), 64'd0);
        chk("loop_round_hold", 64'(loop_round), 64'd6);

        // Boundary: last non-final round.
        le.rnd = 5'd23;
        le.st  = lane0(64'h55);
        loop_q.push_back(le);
        issue(6'd22, lane0(64'h55));
        chk("loop22_o_valid", 64'(o_valid), 64'd0);
        step();

        // Final capture and hold with o_ready low.
        out_q.push_back(lane0(64'hDEADBEEF));
        issue(6'd23, lane0(64'hDEADBEEF));
        chk("final_loop_good", 64'(loop_good), 64'd0);
        chk("final_o_valid", 64'(o_valid), 64'd1);
        chk("final_o0", o[0], 64'hDEADBEEF);
        chk("final_ofull", 64'(ofull), 64'd1);
        for (int c = 0; c < 5; c++) step();
        chk("hold_o_valid", 64'(o_valid), 64'd1);
        chk("hold_o0", o[0], 64'hDEADBEEF);

        // Drain.
        o_ready = 1'b1;
        #1;
        chk("drain_ofull", 64'(ofull), 64'd0);
        step();
        o_ready = 1'b0;
        chk("drain_o_valid", 64'(o_valid), 64'd0);
        chk("drain_o_hold", o[0], 64'hDEADBEEF);
        chk("drain_hash", 64'(hash_count), HC_EN ? 64'd1 : 64'd0);

        // Drain and load in the same cycle.
        out_q.push_back(lane0(64'h3));
        issue(6'd23, lane0(64'h3));
        out_q.push_back(lane0(64'h2));
        o_ready = 1'b1;
        issue(6'd23, lane0(64'h2));
        o_ready = 1'b0;
        chk("dl_o_valid", 64'(o_valid), 64'd1);
        chk("dl_o0", o[0], 64'h2);
        chk("dl_overrun", 64'(overrun), 64'd0);
        chk("dl_hash", 64'(hash_count), HC_EN ? 64'd2 : 64'd0);

        // Overrun: held result not drained, second final arrives.
        issue(6'd23, lane0(64'h1));
        chk("ovr_o0", o[0], 64'h2);
        chk("ovr_flag", 64'(overrun), 64'd1);
        step();
        step();
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Illegal round index.
        issue(6'd40, lane0(64'h77));
        chk("bad_loop_good", 64'(loop_good), 64'd0);
        chk("bad_o_valid", 64'(o_valid), 64'd1);
        chk("bad_o0", o[0], 64'h2);
        chk("bad_flag", 64'(bad_round), 64'd1);
        chk("bad_loop_round", 64'(loop_round), 64'd23);

        // sample low: inputs ignored.
        iround = 6'd3;
        i      = lane0(64'h99);
        step();
        step();
        chk("idle_loop_good", 64'(loop_good), 64'd0);
        chk("idle_loop_o", loop_o[0], 64'h55);
        i      = '0;
        iround = '0;

        // Asynchronous reset between edges while a result is held.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_o_valid", 64'(o_valid), 64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        chk("arst_bad", 64'(bad_round), 64'd0);
        chk("arst_hash", 64'(hash_count), 64'd0);
        chk_state("arst_o", o, '0);
        out_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_o_valid", 64'(o_valid), 64'd0);
        chk("loop_q_empty", 64'(loop_q.size()), 64'd0);
        chk("out_q_empty", 64'(out_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
